// File: rtl/kmap_learner_pkg.sv
// Shared types and constants for the Karnaugh-map learner.
// Optional SOP mask outputs are enabled with KMAP_LEARNER_SOP_EN.
package kmap_pkg;

  localparam int NX_DEFAULT = 4;
  localparam int DEPTH      = 2 ** NX_DEFAULT;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  typedef struct packed {
    logic known;
    logic f;
  } entry_t;

endpackage

// File: rtl/kmap_learner_if.sv
// Observation, lookup, sweep and status bundle of the K-map learner.
// KMAP_LEARNER_SOP_EN adds the on_mask/dc_mask views of the table.
interface kmap_learner_if #(parameter int NX = kmap_pkg::NX_DEFAULT);

  logic              s_valid;
  logic              s_ready;
  logic [NX-1:0]     s_x;
  logic              s_f;
  logic              q_valid;
  logic [NX-1:0]     q_x;
  logic              r_valid;
  logic              r_f;
  logic              r_known;
  logic              dump_start;
  logic              dump_busy;
  logic              d_valid;
  logic [NX-1:0]     d_x;
  logic              d_f;
  logic              d_known;
  logic              conflict;
  logic [NX-1:0]     conflict_x;
  logic [NX:0]       learned_cnt;
`ifdef KMAP_LEARNER_SOP_EN
  logic [2**NX-1:0]  on_mask;
  logic [2**NX-1:0]  dc_mask;
`endif

  modport master (
`ifdef KMAP_LEARNER_SOP_EN
    input  on_mask, dc_mask,
`endif
    output s_valid, s_x, s_f, q_valid, q_x, dump_start,
    input  s_ready, r_valid, r_f, r_known, dump_busy, d_valid, d_x, d_f,
           d_known, conflict, conflict_x, learned_cnt
  );

  modport slave (
`ifdef KMAP_LEARNER_SOP_EN
    output on_mask, dc_mask,
`endif
    input  s_valid, s_x, s_f, q_valid, q_x, dump_start,
    output s_ready, r_valid, r_f, r_known, dump_busy, d_valid, d_x, d_f,
           d_known, conflict, conflict_x, learned_cnt
  );

endinterface

// File: rtl/kmap_learner_table.sv
// Truth-table storage: registered read-old lookup port, one write port,
// and the whole table exposed for the sweep and mask views.
module kmap_table
  import kmap_pkg::*;
#(
  parameter int NX = NX_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rd_en,
  input  logic [NX-1:0] rd_addr,
  output entry_t        rd_data,
  input  logic          we,
  input  logic [NX-1:0] wr_addr,
  input  entry_t        wr_data,
  output entry_t        mem [2**NX]
);

  // Unknown entries keep f=0, so a lookup of an unknown entry returns f=0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2**NX; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (we) mem[wr_addr] <= wr_data;
      rd_data <= rd_en ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/kmap_learner.sv
// Learns a boolean function from observed samples, flags contradictions and
// streams the table on request. KMAP_LEARNER_SOP_EN adds on_mask/dc_mask.
module kmap_learner
  import kmap_pkg::*;
#(
  parameter int NX = NX_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  kmap_learner_if.slave bus
);

  localparam int          TBL  = 2 ** NX;
  localparam logic [NX:0] FULL = (NX + 1)'(TBL);

  state_t        state_q, state_d;
  logic [NX-1:0] dump_cnt_q, dump_cnt_d;
  entry_t        tbl [TBL];
  entry_t        rd_data;
  entry_t        cur;
  entry_t        wr_data;
  logic          accept, we, clash, dumping;

  kmap_table #(.NX(NX)) u_table (
    .clk     (clk),
    .resetn  (resetn),
    .rd_en   (bus.q_valid),
    .rd_addr (bus.q_x),
    .rd_data (rd_data),
    .we      (we),
    .wr_addr (bus.s_x),
    .wr_data (wr_data),
    .mem     (tbl)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      dump_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dump_cnt_q <= dump_cnt_d;
    end
  end

  // A dump_start arriving in DUMP is ignored; the counter parks at 0 in IDLE.
  always_comb begin
    state_d    = state_q;
    dump_cnt_d = dump_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.dump_start) begin
          state_d    = DUMP;
          dump_cnt_d = '0;
        end
      end
      DUMP: begin
        if (dump_cnt_q == NX'(TBL - 1)) begin
          state_d    = IDLE;
          dump_cnt_d = '0;
        end else begin
          dump_cnt_d = dump_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        dump_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    dumping = (state_q == DUMP);
    accept  = bus.s_valid && !dumping;
    cur     = tbl[bus.s_x];
    we      = accept && !cur.known;
    clash   = accept && cur.known && (cur.f != bus.s_f);
    wr_data = '{known: 1'b1, f: bus.s_f};
  end

  // The first contradictory address is frozen; the stored value is never overwritten.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.learned_cnt <= '0;
      bus.conflict    <= 1'b0;
      bus.conflict_x  <= '0;
      bus.r_valid     <= 1'b0;
    end else begin
      if (we && bus.learned_cnt != FULL) bus.learned_cnt <= bus.learned_cnt + 1'b1;
      if (clash) begin
        bus.conflict <= 1'b1;
        if (!bus.conflict) bus.conflict_x <= bus.s_x;
      end
      bus.r_valid <= bus.q_valid;
    end
  end

  // The sweep reads the live table, so a sample accepted with dump_start shows up.
  assign bus.s_ready   = !dumping;
  assign bus.r_known   = rd_data.known;
  assign bus.r_f       = rd_data.known & rd_data.f;
  assign bus.dump_busy = dumping;
  assign bus.d_valid   = dumping;
  assign bus.d_x       = dump_cnt_q;
  assign bus.d_known   = dumping & tbl[dump_cnt_q].known;
  assign bus.d_f       = dumping & tbl[dump_cnt_q].f;

`ifdef KMAP_LEARNER_SOP_EN
  always_comb begin
    bus.on_mask = '0;
    bus.dc_mask = '0;
    for (int i = 0; i < TBL; i++) begin
      bus.on_mask[i] = tbl[i].known & tbl[i].f;
      bus.dc_mask[i] = !tbl[i].known;
    end
  end
`endif

endmodule

// File: tb/tb_kmap_learner.sv
// Scoreboard bench for kmap_learner: stimulus queues expected lookup and
// sweep responses, a negedge monitor pops and compares them.
module tb_kmap_learner;

  logic clk = 1'b0;
  logic resetn;
  int   nChecks = 0;
  int   nFail   = 0;

  logic [1:0] lookupQ [$];
  logic [5:0] dumpQ   [$];

  kmap_learner_if #(.NX(4)) bus ();

  kmap_learner #(.NX(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every presented response must match the head of its queue.
  always @(negedge clk) begin
    logic [1:0] expL;
    logic [5:0] expD;
    if (bus.r_valid) begin
      nChecks++;
      if (lookupQ.size() == 0) begin
        nFail++;
        $display("[TB] FAIL lookup: unexpected r_valid, got known=%0b f=%0b", bus.r_known, bus.r_f);
      end else begin
        expL = lookupQ.pop_front();
        if ({bus.r_known, bus.r_f} !== expL) begin
          nFail++;
          $display("[TB] FAIL lookup: got known/f=%b expected %b", {bus.r_known, bus.r_f}, expL);
        end
      end
    end
    if (bus.d_valid) begin
      nChecks++;
      if (dumpQ.size() == 0) begin
        nFail++;
        $display("[TB] FAIL dump_beat: unexpected d_valid at d_x=%0d", bus.d_x);
      end else begin
        expD = dumpQ.pop_front();
        if ({bus.d_x, bus.d_known, bus.d_f} !== expD) begin
          nFail++;
          $display("[TB] FAIL dump_beat: got x=%0d known=%0b f=%0b expected x=%0d known=%0b f=%0b",
                   bus.d_x, bus.d_known, bus.d_f, expD[5:2], expD[1], expD[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus; a lookup pushes its hand-computed {known,f}.
  task automatic applyStimulus(input logic sv, input logic [3:0] sx, input logic sf,
                               input logic qv, input logic [3:0] qx, input logic [1:0] qexp,
                               input logic ds);
    bus.s_valid    = sv;
    bus.s_x        = sx;
    bus.s_f        = sf;
    bus.q_valid    = qv;
    bus.q_x        = qx;
    bus.dump_start = ds;
    if (qv) lookupQ.push_back(qexp);
    tick();
    bus.s_valid    = 1'b0;
    bus.q_valid    = 1'b0;
    bus.dump_start = 1'b0;
  endtask

  task automatic pushDump(input logic [15:0] knownMask, input logic [15:0] onMask, input int beats);
    for (int i = 0; i < beats; i++) begin
      logic [3:0] xi;
      xi = 4'(i);
      dumpQ.push_back({xi, knownMask[i], onMask[i]});
    end
  endtask

  initial begin
    int        wx [9];
    logic      wf [9];
    wx = '{2, 4, 6, 7, 8, 9, 11, 12, 14};
    wf = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    resetn         = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_x        = '0;
    bus.s_f        = 1'b0;
    bus.q_valid    = 1'b0;
    bus.q_x        = '0;
    bus.dump_start = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;

    checkOutput("reset_s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("reset_learned_cnt", 32'(bus.learned_cnt), 32'd0);
    checkOutput("reset_conflict", 32'(bus.conflict), 32'd0);
    checkOutput("reset_busy_dvalid", 32'({bus.dump_busy, bus.d_valid, bus.r_valid}), 32'd0);

    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'(wx[i]), wf[i], 1'b0, 4'd0, 2'b00, 1'b0);
    checkOutput("learned_cnt_9", 32'(bus.learned_cnt), 32'd9);
    checkOutput("no_conflict", 32'(bus.conflict), 32'd0);

    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd11, 2'b11, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd13, 2'b00, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd2,  2'b10, 1'b0);

    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 2'b00, 1'b0);
    checkOutput("conflict_set", 32'(bus.conflict), 32'd1);
    checkOutput("conflict_x_7", 32'(bus.conflict_x), 32'd7);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
    checkOutput("conflict_x_kept", 32'(bus.conflict_x), 32'd7);
    checkOutput("learned_cnt_after_conflict", 32'(bus.learned_cnt), 32'd9);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 2'b10, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 2'b11, 1'b0);

    // Same-cycle write and lookup of entry 5 must return the old (unknown) value.
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 2'b00, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 2'b11, 1'b0);
    checkOutput("learned_cnt_10", 32'(bus.learned_cnt), 32'd10);
`ifdef KMAP_LEARNER_SOP_EN
    checkOutput("on_mask", 32'(bus.on_mask), 32'h5870);
    checkOutput("dc_mask", 32'(bus.dc_mask), 32'hA40B);
`endif

    // Sweep 1: dump_start held a second cycle while already sweeping.
    pushDump(16'h5BF4, 16'h5870, 16);
    bus.dump_start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput($sformatf("dump_busy_%0d", i), 32'({bus.dump_busy, bus.s_ready}), 32'b10);
      if (i == 1) bus.dump_start = 1'b0;
      if (i == 3) begin
        bus.q_valid = 1'b1;
        bus.q_x     = 4'd11;
        lookupQ.push_back(2'b11);
      end
      if (i == 4) bus.q_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("dump_end_idle", 32'({bus.dump_busy, bus.d_valid, bus.s_ready}), 32'b001);
    checkOutput("dump1_all_beats", 32'(dumpQ.size()), 32'd0);
    tick();

    // Sweep 2: sample (0,1) accepted together with dump_start.
    pushDump(16'h5BF5, 16'h5871, 16);
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b1);
    repeat (17) @(negedge clk);
    checkOutput("dump2_all_beats", 32'(dumpQ.size()), 32'd0);
    checkOutput("learned_cnt_11", 32'(bus.learned_cnt), 32'd11);
    tick();

    // Sweep 3: reset asserted while beat 5 is shown.
    pushDump(16'h5BF5, 16'h5871, 6);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1);
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_dvalid", 32'({bus.d_valid, bus.dump_busy}), 32'd0);
    checkOutput("abort_beats_seen", 32'(dumpQ.size()), 32'd0);
    checkOutput("abort_learned_cnt", 32'(bus.learned_cnt), 32'd0);
    checkOutput("abort_conflict", 32'({bus.conflict, bus.conflict_x}), 32'd0);
    checkOutput("abort_s_ready", 32'(bus.s_ready), 32'd1);
`ifdef KMAP_LEARNER_SOP_EN
    checkOutput("abort_dc_mask", 32'(bus.dc_mask), 32'hFFFF);
    checkOutput("abort_on_mask", 32'(bus.on_mask), 32'h0000);
`endif
    tick();

    for (int i = 0; i < 16; i++) begin
      logic [3:0] xi;
      xi = 4'(i);
      applyStimulus(1'b1, xi, xi[0], 1'b0, 4'd0, 2'b00, 1'b0);
    end
    checkOutput("learned_cnt_full", 32'(bus.learned_cnt), 32'd16);
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 2'b00, 1'b0);
    checkOutput("learned_cnt_sat", 32'(bus.learned_cnt), 32'd16);
    checkOutput("full_no_conflict", 32'(bus.conflict), 32'd0);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
    checkOutput("full_conflict_x", 32'({bus.conflict, bus.conflict_x}), 32'h13);
`ifdef KMAP_LEARNER_SOP_EN
    checkOutput("full_on_mask", 32'(bus.on_mask), 32'hAAAA);
    checkOutput("full_dc_mask", 32'(bus.dc_mask), 32'h0000);
`endif
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 2'b11, 1'b0);
    repeat (2) tick();
    checkOutput("lookups_drained", 32'(lookupQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
